engine_writeback: RTL

//  DMA-side receiver for the engine writeback path. Collects serial 16-bit

---
 rtl/engine_writeback.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/engine_writeback.sv
// engine_writeback: packs serial FP16 engine results into BURST_LEN-lane words and
// queues them for a valid/ready consumer. Define WB_OVERFLOW_FLAG_EN to expose drop reporting.
module engine_writeback #(
    parameter int BURST_LEN = 8,
    parameter int DEPTH     = 4,
    parameter int CNT_W     = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   output_en,
    input  logic [15:0]            output_data,
    input  logic                   gemm_finish,
    output logic [CNT_W-1:0]       output_count,
    output logic [16*BURST_LEN-1:0] wb_data,
    output logic [BURST_LEN-1:0]   wb_mask,
    output logic                   wb_last,
    output logic                   wb_valid,
    input  logic                   wb_ready,
    output logic                   wb_full
`ifdef WB_OVERFLOW_FLAG_EN
    ,
    output logic                   wb_overflow,
    output logic [7:0]             wb_drop_count
`endif
);

    localparam int W      = 16 * BURST_LEN;
    localparam int IDX_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FCNT_W = $clog2(DEPTH + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BURST_LEN - 1);
    localparam logic [FCNT_W-1:0] FULL_CNT = FCNT_W'(DEPTH);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [IDX_W-1:0]     idx;
    logic [W-1:0]         pack;
    logic [W-1:0]         pack_beat;
    logic                 gemm_prev;
    logic                 rise;
    logic                 beat;
    logic                 last_lane;
    logic                 pop;
    logic                 can_push;
    logic                 push_req;
    logic                 push;
    logic [W-1:0]         push_data;
    logic [BURST_LEN-1:0] push_mask;
    logic [BURST_LEN-1:0] part_mask;
    logic                 push_last;

    logic [W-1:0]         fifo_data [DEPTH];
    logic [BURST_LEN-1:0] fifo_mask [DEPTH];
    logic                 fifo_last [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [FCNT_W-1:0]    fifo_cnt;

    assign wb_valid  = (fifo_cnt != '0);
    assign wb_full   = (fifo_cnt == FULL_CNT);
    assign pop       = wb_valid & wb_ready;
    assign can_push  = !wb_full || pop;
    assign rise      = gemm_finish & ~gemm_prev;
    assign beat      = (state == FILL) && output_en;
    assign last_lane = (idx == LAST_IDX);
    assign push      = push_req & can_push;

    // Gate the head with wb_valid so an empty FIFO presents all-zero outputs.
    assign wb_data = wb_valid ? fifo_data[rd_ptr] : '0;
    assign wb_mask = wb_valid ? fifo_mask[rd_ptr] : '0;
    assign wb_last = wb_valid ? fifo_last[rd_ptr] : 1'b0;

    always_comb begin
        pack_beat = pack;
        pack_beat[16*idx +: 16] = output_data;
        part_mask = '0;
        for (int i = 0; i < BURST_LEN; i++) begin
            part_mask[i] = (IDX_W'(i) < idx);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        push_req  = 1'b0;
        push_data = '0;
        push_mask = '0;
        push_last = 1'b0;
        case (state)
            FILL: begin
                if (beat && last_lane) begin
                    push_req  = 1'b1;
                    push_data = pack_beat;
                    push_mask = '1;
                end
                if (rise) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                // Unused lanes of pack are already zero, so idx==0 yields the terminator.
                push_req  = 1'b1;
                push_data = pack;
                push_mask = part_mask;
                push_last = 1'b1;
                if (can_push) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (!gemm_finish) begin
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gemm_prev    <= 1'b0;
            idx          <= '0;
            pack         <= '0;
            output_count <= '0;
        end else begin
            gemm_prev <= gemm_finish;
            if (beat) begin
                output_count <= output_count + 1'b1;
                if (last_lane) begin
                    idx  <= '0;
                    pack <= '0;
                end else begin
                    idx  <= idx + 1'b1;
                    pack <= pack_beat;
                end
            end
            if (state == FLUSH && can_push) begin
                idx  <= '0;
                pack <= '0;
            end
            if (state == DONE && !gemm_finish) begin
                output_count <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= push_data;
            fifo_mask[wr_ptr] <= push_mask;
            fifo_last[wr_ptr] <= push_last;
        end
    end

    // Simultaneous push and pop leaves the occupancy unchanged, even when full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

`ifdef WB_OVERFLOW_FLAG_EN
    logic drop;
    assign drop = push_req & ~can_push;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_overflow   <= 1'b0;
            wb_drop_count <= '0;
        end else if (drop) begin
            wb_overflow <= 1'b1;
            if (wb_drop_count != 8'hFF) begin
                wb_drop_count <= wb_drop_count + 8'd1;
            end
        end
    end
`endif

endmodule
